// File: rtl/spirose_pkg.sv
// Shared constants and types for the rotation-synchronised display pipeline.
// NB_SLICES_DEFAULT : slices per rotation used when a block is not overridden
// slice_idx_t       : slice index type shared with the column/slice scheduler
package spirose_pkg;

  localparam int unsigned NB_SLICES_DEFAULT = 128;
  localparam int unsigned SLICE_IDX_W       = $clog2(NB_SLICES_DEFAULT);

  typedef logic [SLICE_IDX_W-1:0] slice_idx_t;

endpackage

// File: rtl/slice_accumulator.sv
// Splits one rotation into NB_SLICES evenly spaced ticks without a divider.
// Each cycle the accumulator gains NB_SLICES. Whenever it reaches the period, a
// tick is issued and the period is subtracted. The index saturates at the last
// slice, so a rotation that runs long holds its final slice instead of wrapping.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_period     : rotation period in cycles (previous rotation)
//   i_restart    : start of a rotation; tick with index 0, accumulator cleared
//   i_enable     : slicing allowed (period valid and not stalling)
//   o_tick       : 1-cycle pulse at the start of each slice
//   o_idx        : current slice index
module slice_accumulator
  import spirose_pkg::*;
#(
  parameter int unsigned NB_SLICES = NB_SLICES_DEFAULT,
  parameter int unsigned PERIOD_W  = 24,
  localparam int unsigned IDX_W    = $clog2(NB_SLICES)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_restart,
  input  logic                i_enable,
  output logic                o_tick,
  output logic [IDX_W-1:0]    o_idx
);

  localparam int unsigned ACC_W = PERIOD_W + 1;
  localparam logic [ACC_W-1:0] ACC_STEP = ACC_W'(NB_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_SLICES - 1);

  logic [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0] r_idx;
  logic             r_tick;

  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_period;
  logic             w_hit;
  logic             w_last;

  assign w_sum    = r_acc + ACC_STEP;
  assign w_period = {1'b0, i_period};
  assign w_hit    = (w_sum >= w_period);
  // Once the last slice is reached the accumulator freezes until the next restart.
  assign w_last   = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_idx  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_restart) begin
        r_acc  <= '0;
        r_idx  <= '0;
        r_tick <= 1'b1;
      end else if (i_enable && !w_last) begin
        if (w_hit) begin
          r_acc  <= w_sum - w_period;
          r_idx  <= r_idx + IDX_W'(1);
          r_tick <= 1'b1;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign o_tick = r_tick;
  assign o_idx  = r_idx;

endmodule

// File: rtl/rotation_slicer.sv
// Measures the rotation period between accepted hall rising edges and slices the
// following rotation into NB_SLICES ticks with a running slice index.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_hall_sync    : synchronised hall level
//   o_rot_start    : 1-cycle pulse on each accepted rising edge
//   o_slice_tick   : 1-cycle pulse at the start of every slice
//   o_slice_idx    : current slice index, meaningful while o_period_valid
//   o_period       : last measured rotation period in cycles
//   o_period_valid : a period is measured and the rotor is not stalled
//   o_stalled      : no accepted edge for 2**PERIOD_W-1 cycles
module rotation_slicer
  import spirose_pkg::*;
#(
  parameter int unsigned NB_SLICES  = NB_SLICES_DEFAULT,
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned MIN_PERIOD = 1000,
  localparam int unsigned IDX_W     = $clog2(NB_SLICES)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_hall_sync,
  output logic                o_rot_start,
  output logic                o_slice_tick,
  output logic [IDX_W-1:0]    o_slice_idx,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_period_valid,
  output logic                o_stalled
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] CNT_MIN = PERIOD_W'(MIN_PERIOD);

  logic                r_hall_q;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_armed;
  logic [PERIOD_W-1:0] r_period;
  logic                r_period_valid;
  logic                r_stalled;
  logic                r_rot_start;

  logic w_rise;
  logic w_accept;
  logic w_measure;
  logic w_stall_set;

  assign w_rise      = i_hall_sync & ~r_hall_q;
  // The first edge after reset or a stall has no reference, so lockout does not apply.
  assign w_accept    = w_rise & (~r_armed | (r_cnt >= CNT_MIN));
  assign w_measure   = w_accept & r_armed;
  // An accepted edge on the saturation cycle wins over the stall.
  assign w_stall_set = ~w_accept & (r_cnt == CNT_MAX) & ~r_stalled;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // A level already high at release must not look like an edge.
      r_hall_q       <= 1'b1;
      r_cnt          <= '0;
      r_armed        <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_stalled      <= 1'b0;
      r_rot_start    <= 1'b0;
    end else begin
      r_hall_q    <= i_hall_sync;
      r_rot_start <= w_accept;
      if (w_accept) begin
        r_cnt     <= PERIOD_W'(1);
        r_armed   <= 1'b1;
        r_stalled <= 1'b0;
        if (r_armed) begin
          r_period       <= r_cnt;
          r_period_valid <= 1'b1;
        end
      end else begin
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + PERIOD_W'(1);
        end
        if (w_stall_set) begin
          r_stalled      <= 1'b1;
          r_period_valid <= 1'b0;
          r_armed        <= 1'b0;
        end
      end
    end
  end

  slice_accumulator #(
    .NB_SLICES(NB_SLICES),
    .PERIOD_W (PERIOD_W)
  ) u_slice_accumulator (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_period (r_period),
    .i_restart(w_measure),
    .i_enable (r_period_valid & ~w_stall_set),
    .o_tick   (o_slice_tick),
    .o_idx    (o_slice_idx)
  );

  assign o_rot_start    = r_rot_start;
  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;
  assign o_stalled      = r_stalled;

endmodule
